inst_fetch_ctrl: RTL

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl_pkg.sv | 19 +
 rtl/inst_fetch_ctrl_if.sv | 29 ++
 rtl/inst_fetch_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared widths and state encoding for the instruction fetch controller.
package inst_fetch_ctrl_pkg;

  localparam int unsigned InstAddrBus = 32;  // instruction address width
  localparam int unsigned InstBus     = 32;  // instruction word width
  localparam int unsigned ByteBus     = 8;   // memory return width

  // IDLE   : serve hits, launch a refill on a miss
  // FETCH  : issue byte addresses and assemble returned bytes
  // WRITE  : one cycle of cache fill plus delivery to IF
  // DRAIN  : swallow returns still owed by memory after a flush
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Byte-wide memory request/return channel between the fetch controller and memory.
interface inst_fetch_ctrl_if;
  import inst_fetch_ctrl_pkg::*;

  logic                   mem_req_o;
  logic [InstAddrBus-1:0] mem_addr_o;
  logic                   mem_gnt_i;
  logic                   mem_rvalid_i;
  logic [ByteBus-1:0]     mem_data_i;

  // Fetch controller side.
  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_data_i
  );

  // Memory side.
  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_data_i
  );

endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: zero-latency cache hits, byte-serial refill on
// a miss with overlapped issue/return, flush with drain of outstanding returns.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  // Bytes per instruction, little-endian; at most InstBus/ByteBus.
  parameter int unsigned INST_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   req_i,
  input  logic [InstAddrBus-1:0] pc_i,
  input  logic                   flush_i,
  output logic                   inst_valid_o,
  output logic [InstBus-1:0]     inst_o,
  output logic [InstAddrBus-1:0] rpc_o,
  input  logic                   hit_i,
  input  logic [InstBus-1:0]     cinst_i,
  output logic                   we_o,
  output logic [InstAddrBus-1:0] wpc_o,
  output logic [InstBus-1:0]     winst_o,
  inst_fetch_ctrl_if.master      mem
);

  localparam int unsigned      CntW     = $clog2(INST_BYTES + 1);
  localparam logic [CntW-1:0]  NumBytes = CntW'(INST_BYTES);
  localparam logic [CntW-1:0]  LastByte = CntW'(INST_BYTES - 1);

  fetch_state_e           state_q, state_d;
  logic [CntW-1:0]        issued_q, issued_d;
  logic [CntW-1:0]        received_q, received_d;
  logic [InstBus-1:0]     buf_q, buf_d;
  logic [InstAddrBus-1:0] pc_q, pc_d;
  logic [CntW-1:0]        recv_sum;

  // The cache is always looked up with the live fetch address.
  assign rpc_o = pc_i;

  // Next-state, counter, byte-assembly and output decode.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave one unassigned, which would otherwise infer a latch.
    state_d          = state_q;
    issued_d         = issued_q;
    received_d       = received_q;
    buf_d            = buf_q;
    pc_d             = pc_q;
    inst_valid_o     = 1'b0;
    inst_o           = '0;
    we_o             = 1'b0;
    wpc_o            = '0;
    winst_o          = '0;
    mem.mem_req_o    = 1'b0;
    mem.mem_addr_o   = '0;
    recv_sum         = received_q + CntW'(mem.mem_rvalid_i);

    // Reset masks every output; rdy low holds all state at its defaults.
    if (rst && rdy) begin
      // A redirect throws away any partly assembled instruction.
      if (flush_i) begin
        buf_d = '0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (req_i && !flush_i) begin
            if (hit_i) begin
              inst_valid_o = 1'b1;
              inst_o       = cinst_i;
            end else begin
              pc_d       = pc_i;
              issued_d   = '0;
              received_d = '0;
              buf_d      = '0;
              state_d    = ST_FETCH;
            end
          end
        end

        ST_FETCH: begin
          if (flush_i) begin
            // Bytes still owed by memory must be swallowed before going idle.
            received_d = recv_sum;
            state_d    = (issued_q > recv_sum) ? ST_DRAIN : ST_IDLE;
          end else begin
            if (issued_q < NumBytes) begin
              mem.mem_req_o  = 1'b1;
              mem.mem_addr_o = pc_q + InstAddrBus'(issued_q);
              if (mem.mem_gnt_i) begin
                issued_d = issued_q + CntW'(1);
              end
            end
            if (mem.mem_rvalid_i) begin
              for (int k = 0; k < INST_BYTES; k++) begin
                if (received_q == CntW'(k)) begin
                  buf_d[ByteBus*k +: ByteBus] = mem.mem_data_i;
                end
              end
              received_d = recv_sum;
              if (received_q == LastByte) begin
                state_d = ST_WRITE;
              end
            end
          end
        end

        ST_WRITE: begin
          if (!flush_i) begin
            we_o         = 1'b1;
            wpc_o        = pc_q;
            winst_o      = buf_q;
            inst_valid_o = 1'b1;
            inst_o       = buf_q;
          end
          state_d = ST_IDLE;
        end

        ST_DRAIN: begin
          received_d = recv_sum;
          if (recv_sum == issued_q) begin
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, counters, byte buffer and latched fetch address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the byte buffer is a handful of flops, not a RAM, so it is
      // reset with the rest of the state; a fresh refill never sees stale data.
      state_q    <= ST_IDLE;
      issued_q   <= '0;
      received_q <= '0;
      buf_q      <= '0;
      pc_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state_q    <= state_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      buf_q      <= buf_d;
      pc_q       <= pc_d;
    end
  end

endmodule
